// File: rtl/unsigned_16by8_div_seq.sv
// ============================================================================
// unsigned_16by8_div_seq : sequential restoring divider, 16-bit / 8-bit -> q16, r8
// Revision 1.0
// ============================================================================
`default_nettype none

module unsigned_16by8_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] z,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic [7:0]  r,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] acc;       // dividend shifts out of the MSB, quotient bits enter at the LSB
  logic [7:0]  divisor;
  logic [7:0]  prem;
  logic [3:0]  cnt;

  logic [8:0]  trial;
  logic        take;
  logic [7:0]  diff;

  // The 9-bit trial value cannot overflow; a successful subtract always fits in 8 bits.
  assign trial = {prem, acc[15]};
  assign take  = (trial >= {1'b0, divisor});
  assign diff  = trial[7:0] - divisor;

  assign q = acc;
  assign r = prem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= 16'd0;
      divisor     <= 8'd0;
      prem        <= 8'd0;
      cnt         <= 4'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            divisor  <= y;
            cnt      <= 4'd0;
            in_ready <= 1'b0;
            if (y == 8'd0) begin
              acc         <= 16'hFFFF;
              prem        <= z[7:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= ST_DONE;
            end else begin
              acc         <= z;
              prem        <= 8'd0;
              div_by_zero <= 1'b0;
              state       <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          acc  <= {acc[14:0], take};
          prem <= take ? diff : trial[7:0];
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Results must not move while the consumer is stalling.
  a_hold_under_backpressure: assert property (
    @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(q) && $stable(r) && $stable(div_by_zero))
  );

  a_ready_valid_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(in_ready && out_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_unsigned_16by8_div_seq.sv
// Testbench for unsigned_16by8_div_seq: directed vector table, corner sequences
// and a randomized sweep checked against plain integer division.
`default_nettype none

module tb_unsigned_16by8_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unsigned_16by8_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .z           (z),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [15:0] z;
    logic [7:0]  y;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present one operation; returns at the negedge after the accepting posedge.
  task automatic start_op(input logic [15:0] zz, input logic [7:0] yy);
    @(negedge clk);
    chk("in_ready before accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    z        = zz;
    y        = yy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    z        = 16'($urandom);
    y        = 8'($urandom);
  endtask

  // Counts posedges from the accepting edge until out_valid is seen (bounded).
  task automatic wait_done(input bit churn, output int lat);
    bit busy_ready_seen;
    busy_ready_seen = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (churn) begin
        in_valid = 1'($urandom);
        z        = 16'($urandom);
        y        = 8'($urandom);
      end
      if (in_ready) busy_ready_seen = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (churn) chk("in_ready low during busy", {31'd0, busy_ready_seen}, 32'd0);
    if (!out_valid) chk("timeout waiting out_valid", 32'd0, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid after handshake", {31'd0, out_valid}, 32'd0);
    chk("in_ready after handshake", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] zz, input logic [7:0] yy,
                               input logic [15:0] eq, input logic [7:0] er, input logic edz,
                               input bit churn);
    int lat;
    start_op(zz, yy);
    wait_done(churn, lat);
    chk({tag, " latency"}, lat, edz ? 32'd1 : 32'd17);
    chk({tag, " q"}, {16'd0, q}, {16'd0, eq});
    chk({tag, " r"}, {24'd0, r}, {24'd0, er});
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    consume();
  endtask

  initial begin
    int lat;
    bit stable_ok;

    tbl[0]  = '{16'd40000, 8'd200, 16'd200,   8'd0,   1'b0};
    tbl[1]  = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
    tbl[2]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    tbl[3]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
    tbl[4]  = '{16'd100,   8'd255, 16'd0,     8'd100, 1'b0};
    tbl[5]  = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1};
    tbl[6]  = '{16'd10,    8'd3,   16'd3,     8'd1,   1'b0};
    tbl[7]  = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0};
    tbl[8]  = '{16'd12345, 8'd1,   16'd12345, 8'd0,   1'b0};
    tbl[9]  = '{16'd200,   8'd201, 16'd0,     8'd200, 1'b0};
    tbl[10] = '{16'd65535, 8'd16,  16'd4095,  8'd15,  1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = 16'd0;
    y         = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset q", {16'd0, q}, 32'd0);
    chk("reset r", {24'd0, r}, 32'd0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);

    for (int i = 0; i < 11; i++)
      run_and_check($sformatf("vec%0d", i), tbl[i].z, tbl[i].y, tbl[i].q, tbl[i].r, tbl[i].dz, 1'b0);

    // Backpressure: result held for 10 stalled cycles.
    start_op(16'd500, 8'd9);
    wait_done(1'b0, lat);
    chk("bp latency", lat, 32'd17);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && q === 16'd55 && r === 8'd5 && div_by_zero === 1'b0))
        stable_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp held stable", {31'd0, stable_ok}, 32'd1);
    chk("bp q", {16'd0, q}, 32'd55);
    chk("bp r", {24'd0, r}, 32'd5);
    consume();

    // Input churn during BUSY must not disturb the result or cause a second accept.
    start_op(16'd300, 8'd4);
    wait_done(1'b1, lat);
    chk("churn latency", lat, 32'd17);
    chk("churn q", {16'd0, q}, 32'd75);
    chk("churn r", {24'd0, r}, 32'd0);
    consume();

    // Asynchronous reset eight cycles into BUSY.
    start_op(16'd9999, 8'd3);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset q", {16'd0, q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("after reset", 16'd9999, 8'd3, 16'd3333, 8'd0, 1'b0, 1'b0);

    // Randomized sweep against integer division.
    for (int n = 0; n < 2000; n++) begin
      int zi, yi;
      logic [15:0] eq;
      logic [7:0]  er;
      zi = int'($urandom_range(65535, 0));
      yi = ($urandom_range(15, 0) == 0) ? 0 : int'($urandom_range(255, 1));
      if (n == 0) zi = 0;
      if (yi == 0) begin
        eq = 16'hFFFF;
        er = 8'(zi);
      end else begin
        eq = 16'(zi / yi);
        er = 8'(zi % yi);
      end
      run_and_check($sformatf("rnd z=%0d y=%0d", zi, yi), 16'(zi), 8'(yi), eq, er, (yi == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
